// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data memory controller.
// Optional alignment/range checking is enabled by defining DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Wide enough for WAIT_CYCLES in 0..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bytes moved by an access; the reserved encoding behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a requester (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mfa;
    logic              rw;
    logic [1:0]        size;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              moc;
    logic              err;

    modport master (
        output mfa, rw, size, address, data_in,
        input  data_out, moc, err
    );

    modport slave (
        input  mfa, rw, size, address, data_in,
        output data_out, moc, err
    );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte storage as four byte lanes; lane l holds every byte whose address[1:0] == l.
// Rows are rotated per lane so an unaligned access touches four consecutive bytes.
module dmem_byte_array #(
    parameter int DEPTH_BYTES = 512,
    parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [3:0]       wr_en_i,
    input  logic [31:0]      wr_data_i,
    output logic [31:0]      rd_data_o
);
    localparam int ROWS  = DEPTH_BYTES / 4;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ROW_W-1:0] base_row;
    assign base_row = ROW_W'(addr_i >> 2);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0]       lane_mem [ROWS];
        logic [ROW_W-1:0] row;

        // Lanes below the start offset belong to the next row; the add wraps modulo ROWS.
        assign row = (base_row + ROW_W'(2'(l) < addr_i[1:0])) & ROW_W'(ROWS - 1);

        // NOTE: storage has no reset; clearing a RAM costs a cycle per row and nothing needs it.
        always_ff @(posedge clk) begin
            if (wr_en_i[l]) begin
                lane_mem[row] <= wr_data_i[8*l +: 8];
            end
        end

        assign rd_data_o[8*l +: 8] = lane_mem[row];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-stated big-endian byte/halfword/word data memory controller (IDLE/BUSY/DONE FSM).
// Define DMEM_ALIGN_CHECK_EN to flag misaligned, reserved-size and out-of-range requests.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] addr_q;
    logic             rw_q;
    logic [1:0]       size_q;
    logic [31:0]      wdata_q;
    logic             bad_q;
    logic             bad_req;

    logic [31:0]      data_out_q;
    logic             moc_q;

    logic             accept;
    logic             commit;
    logic [2:0]       nbytes;
    logic [1:0]       off;

    logic [3:0]       wr_en;
    logic [31:0]      wr_data;
    logic [31:0]      rd_data;
    logic [31:0]      rd_word;
    logic [1:0]       lane_k   [4];
    logic [1:0]       lane_sel [4];
    logic [1:0]       byte_lane[4];
    logic [7:0]       rd_b     [4];

    assign accept = (state_q == IDLE) && bus.mfa;
    // Reset wins over a completing access so an aborted write never lands.
    assign commit = (state_q == BUSY) && (cnt_q == '0) && !reset;
    assign nbytes = size_bytes(size_q);
    assign off    = addr_q[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (bus.mfa) begin
                state_d = BUSY;
                cnt_d   = CNT_W'(WAIT_CYCLES);
            end
            BUSY: if (cnt_q == '0) state_d = DONE;
                  else             cnt_d   = cnt_q - CNT_W'(1);
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.address[IDX_W-1:0];
            rw_q    <= bus.rw;
            size_q  <= bus.size;
            wdata_q <= bus.data_in;
            bad_q   <= bad_req;
        end
    end

    // Logical byte k (k=0 is the MSB) lives in lane (off+k) mod 4.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        rd_word = '0;
        for (int l = 0; l < 4; l++) begin
            lane_k[l]    = 2'(l) - off;
            lane_sel[l]  = 2'(nbytes - 3'd1) - lane_k[l];
            wr_en[l]     = commit && !rw_q && !bad_q && ({1'b0, lane_k[l]} < nbytes);
            wr_data[8*l +: 8] = wdata_q[8*lane_sel[l] +: 8];
            byte_lane[l] = 2'(l) + off;
            rd_b[l]      = rd_data[8*byte_lane[l] +: 8];
        end
        case (size_q)
            SZ_BYTE: rd_word = {24'h0, rd_b[0]};
            SZ_HALF: rd_word = {16'h0, rd_b[0], rd_b[1]};
            default: rd_word = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
        endcase
    end

    dmem_byte_array #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk      (clk),
        .addr_i   (addr_q),
        .wr_en_i  (wr_en),
        .wr_data_i(wr_data),
        .rd_data_o(rd_data)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            moc_q      <= 1'b0;
            data_out_q <= 32'h0;
        end else begin
            moc_q <= commit;
            if (commit && rw_q && !bad_q) begin
                data_out_q <= rd_word;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.moc      = moc_q;

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;

    assign bad_req = ((bus.size == SZ_HALF) && bus.address[0])
                  || ((bus.size == SZ_WORD) && (bus.address[1:0] != 2'b00))
                  || (bus.size == SZ_RSVD)
                  || ((bus.address >> IDX_W) != '0);

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= commit && bad_q;
    end

    assign bus.err = err_q;
`else
    assign bad_req = 1'b0;
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DEPTH_BYTES=512, WAIT_CYCLES=3); both
// DMEM_ALIGN_CHECK_EN builds are covered by the final section.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int WAIT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    data_mem_ctrl_if #(.ADDR_W(32)) bus ();

    data_mem_ctrl #(
        .DEPTH_BYTES(512),
        .ADDR_W     (32),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; checks latency, err at moc, and that moc drops after one cycle.
    task automatic run_req(input string tag, input logic r, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        int n = 0;
        bit seen = 1'b0;
        @(negedge clk);
        bus.mfa = 1'b1; bus.rw = r; bus.size = sz; bus.address = a; bus.data_in = d;
        @(posedge clk);
        #1 bus.mfa = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus.moc;
        end
        check({tag, "_lat"}, n, WAIT + 1);
        if (seen) check({tag, "_err"}, bus.err, exp_err);
        @(negedge clk);
        check({tag, "_pulse"}, bus.moc, 1'b0);
    endtask

    initial begin
        int  mocs;
        bit  seen;

        bus.mfa = 1'b0; bus.rw = 1'b0; bus.size = SZ_WORD;
        bus.address = '0; bus.data_in = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", bus.data_out, 32'h0);
        check("rst_moc",  bus.moc, 1'b0);
        check("rst_err",  bus.err, 1'b0);
        reset = 1'b0;

        run_req("wr_w10", 1'b0, SZ_WORD, 32'h10, 32'hDEADBEEF, 1'b0);
        check("wr_w10_hold", bus.data_out, 32'h0);
        run_req("rd_w10", 1'b1, SZ_WORD, 32'h10, 32'h0, 1'b0);
        check("rd_w10_data", bus.data_out, 32'hDEADBEEF);
        run_req("rd_b10", 1'b1, SZ_BYTE, 32'h10, 32'h0, 1'b0);
        check("rd_b10_data", bus.data_out, 32'h000000DE);

        run_req("wr_b13", 1'b0, SZ_BYTE, 32'h13, 32'hFFFFFF5A, 1'b0);
        check("wr_b13_hold", bus.data_out, 32'h000000DE);
        run_req("rd_w10b", 1'b1, SZ_WORD, 32'h10, 32'h0, 1'b0);
        check("rd_w10b_data", bus.data_out, 32'hDEADBE5A);
        run_req("rd_h12", 1'b1, SZ_HALF, 32'h12, 32'h0, 1'b0);
        check("rd_h12_data", bus.data_out, 32'h0000BE5A);

        run_req("wr_w14", 1'b0, SZ_WORD, 32'h14, 32'h11223344, 1'b0);
        run_req("wr_h16", 1'b0, SZ_HALF, 32'h16, 32'hFFFFABCD, 1'b0);
        run_req("rd_w14", 1'b1, SZ_WORD, 32'h14, 32'h0, 1'b0);
        check("rd_w14_data", bus.data_out, 32'h1122ABCD);

        // mfa held high: accepts every 6 edges; address is 0x14 except at accept edges.
        @(negedge clk);
        bus.mfa = 1'b1; bus.rw = 1'b1; bus.size = SZ_WORD; bus.address = 32'h10;
        mocs = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.moc) begin
                check("b2b_idx", i, 4 + 6 * mocs);
                check("b2b_data", bus.data_out, 32'hDEADBE5A);
                mocs++;
            end
            bus.address = ((i + 1) % 6 == 0) ? 32'h10 : 32'h14;
            if (i == 23) bus.mfa = 1'b0;
        end
        check("b2b_count", mocs, 4);

        // Reset on the second BUSY cycle of a write aborts it.
        run_req("wr_w20", 1'b0, SZ_WORD, 32'h20, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        bus.mfa = 1'b1; bus.rw = 1'b0; bus.size = SZ_WORD;
        bus.address = 32'h20; bus.data_in = 32'h12345678;
        @(posedge clk);
        #1 bus.mfa = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_moc",  bus.moc, 1'b0);
        check("abort_dout", bus.data_out, 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.moc;
        end
        check("abort_nomoc", seen, 1'b0);
        run_req("rd_w20", 1'b1, SZ_WORD, 32'h20, 32'h0, 1'b0);
        check("rd_w20_data", bus.data_out, 32'hCAFEF00D);

`ifdef DMEM_ALIGN_CHECK_EN
        run_req("chk_w02", 1'b1, SZ_WORD, 32'h02, 32'h0, 1'b1);
        check("chk_w02_hold", bus.data_out, 32'hCAFEF00D);
        run_req("chk_w200", 1'b1, SZ_WORD, 32'h200, 32'h0, 1'b1);
        run_req("chk_h11", 1'b1, SZ_HALF, 32'h11, 32'h0, 1'b1);
        run_req("chk_rsvd", 1'b1, SZ_RSVD, 32'h10, 32'h0, 1'b1);
        run_req("chk_wr_bad", 1'b0, SZ_WORD, 32'h21, 32'h0BADF00D, 1'b1);
        run_req("chk_rd_w20", 1'b1, SZ_WORD, 32'h20, 32'h0, 1'b0);
        check("chk_rd_w20_data", bus.data_out, 32'hCAFEF00D);
        check("chk_hold_all", bus.data_out, 32'hCAFEF00D);
`else
        run_req("wrap_wr", 1'b0, SZ_WORD, 32'h1FE, 32'hA1B2C3D4, 1'b0);
        run_req("wrap_b1fe", 1'b1, SZ_BYTE, 32'h1FE, 32'h0, 1'b0);
        check("wrap_b1fe_data", bus.data_out, 32'h000000A1);
        run_req("wrap_b1ff", 1'b1, SZ_BYTE, 32'h1FF, 32'h0, 1'b0);
        check("wrap_b1ff_data", bus.data_out, 32'h000000B2);
        run_req("wrap_b000", 1'b1, SZ_BYTE, 32'h000, 32'h0, 1'b0);
        check("wrap_b000_data", bus.data_out, 32'h000000C3);
        run_req("wrap_b001", 1'b1, SZ_BYTE, 32'h001, 32'h0, 1'b0);
        check("wrap_b001_data", bus.data_out, 32'h000000D4);
        run_req("rsvd_rd", 1'b1, SZ_RSVD, 32'h10, 32'h0, 1'b0);
        check("rsvd_rd_data", bus.data_out, 32'hDEADBE5A);
        run_req("alias_rd", 1'b1, SZ_WORD, 32'h210, 32'h0, 1'b0);
        check("alias_rd_data", bus.data_out, 32'hDEADBE5A);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
